// File: rtl/nmr_seq_pkg.sv
// Shared types and defaults for the CPMG pulse-sequence engine.
package nmr_seq_pkg;

  localparam int CNT_W_DEF   = 32;
  localparam int NPHASE_DEF  = 4;
  localparam int PHASE_W_DEF = 2;
  localparam int ECHO_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    T1_P180   = 3'd1,
    T1_DLY    = 3'd2,
    P90       = 3'd3,
    DLY_NOACQ = 3'd4,
    P180      = 3'd5,
    DLY_ACQ   = 3'd6
  } seq_state_e;

  // Phase-select offset that rotates the RF phase by 180 degrees.
  function automatic int unsigned phase_half_offset(input int unsigned nphase);
    return nphase / 32'd2;
  endfunction

endpackage

// File: rtl/nmr_interval_counter.sv
// Interval down-counter: loads length-1 (length 0 behaves as 1), flags the last cycle.
module nmr_interval_counter #(
  parameter int CNT_W = 32
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Count register: load on state entry, then count down and rest at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= (load_val == '0) ? '0 : (load_val - ONE);
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == '0);

endmodule

// File: rtl/cpmg_seq_engine.sv
// CPMG sequencer: optional T1 inversion, 90 pulse, N x (180 pulse + acquisition delay),
// with per-pulse RF phase, phase cycling, abort and done pulse. Outputs are registered next-state decodes.
module cpmg_seq_engine
  import nmr_seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int NPHASE  = NPHASE_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ECHO_W  = ECHO_W_DEF
)(
  input  logic               PULSEPROG_CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               ABORT,
  input  logic [CNT_W-1:0]   T1_PULSE180,
  input  logic [CNT_W-1:0]   T1_DELAY,
  input  logic [CNT_W-1:0]   PULSE90,
  input  logic [CNT_W-1:0]   DELAY_NO_ACQ,
  input  logic [CNT_W-1:0]   PULSE180,
  input  logic [CNT_W-1:0]   DELAY_WITH_ACQ,
  input  logic [CNT_W-1:0]   ECHO_PER_SCAN,
  input  logic [CNT_W-1:0]   SAMPLES_PER_ECHO,
  input  logic [CNT_W-1:0]   RX_DELAY,
  input  logic [PHASE_W-1:0] PH90,
  input  logic [PHASE_W-1:0] PH180,
  input  logic               PHASE_CYCLE,
  output logic               FSMSTAT,
  output logic               TX_GATE,
  output logic [PHASE_W-1:0] RF_PHASE,
  output logic               EN_RX,
  output logic               TX_SD,
  output logic               ACQ_WND,
  output logic [ECHO_W-1:0]  ECHO_IDX,
  output logic               DONE
);

  localparam logic [CNT_W-1:0]   ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PHASE_W-1:0] PH_HALF = PHASE_W'(phase_half_offset(NPHASE));

  seq_state_e state_r, next_state_s;

  logic [CNT_W-1:0]   t1p_r, t1d_r, p90_r, dna_r, p180_r, dacq_r, echo_n_r, samp_r, rxd_r;
  logic [PHASE_W-1:0] ph90_r, ph180_r;
  logic               pc_r;
  logic [CNT_W-1:0]   t1p_s, t1d_s, p90_s, dna_s, p180_s, dacq_s, echo_n_s, samp_s, rxd_s;
  logic [PHASE_W-1:0] ph90_s, ph180_s;
  logic               pc_s;
  logic               use_live_s;

  logic               fsmstat_r, tx_gate_r, en_rx_r, acq_wnd_r, done_r;
  logic [PHASE_W-1:0] rf_phase_r;
  logic [CNT_W-1:0]   echo_cnt_r, pos_r;

  logic               start_s, done_s, echo_inc_s, more_echo_s, load_s, tc_s, win_s;
  logic [CNT_W-1:0]   next_echo_s, load_val_s, next_pos_s;
  logic [CNT_W:0]     win_end_s;
  logic [PHASE_W-1:0] p180_ph_s;

  // While idle the live inputs feed the first transition; afterwards the latched copies do.
  assign use_live_s = (state_r == IDLE);
  assign t1p_s    = use_live_s ? T1_PULSE180      : t1p_r;
  assign t1d_s    = use_live_s ? T1_DELAY         : t1d_r;
  assign p90_s    = use_live_s ? PULSE90          : p90_r;
  assign dna_s    = use_live_s ? DELAY_NO_ACQ     : dna_r;
  assign p180_s   = use_live_s ? PULSE180         : p180_r;
  assign dacq_s   = use_live_s ? DELAY_WITH_ACQ   : dacq_r;
  assign echo_n_s = use_live_s ? ECHO_PER_SCAN    : echo_n_r;
  assign samp_s   = use_live_s ? SAMPLES_PER_ECHO : samp_r;
  assign rxd_s    = use_live_s ? RX_DELAY         : rxd_r;
  assign ph90_s   = use_live_s ? PH90             : ph90_r;
  assign ph180_s  = use_live_s ? PH180            : ph180_r;
  assign pc_s     = use_live_s ? PHASE_CYCLE      : pc_r;

  assign start_s     = (state_r == IDLE) && START && !ABORT;
  assign more_echo_s = ({1'b0, echo_cnt_r} + {1'b0, ONE}) < {1'b0, echo_n_s};
  assign load_s      = (next_state_s != state_r) && (next_state_s != IDLE);

  // Acquisition window in CNT_W+1 bits so RX_DELAY+SAMPLES cannot wrap.
  assign next_pos_s = (state_r == DLY_ACQ) ? (pos_r + ONE) : '0;
  assign win_end_s  = {1'b0, rxd_s} + {1'b0, samp_s};
  assign win_s      = ({1'b0, next_pos_s} >= {1'b0, rxd_s}) && ({1'b0, next_pos_s} < win_end_s);
  assign p180_ph_s  = (pc_s && next_echo_s[0]) ? (ph180_s + PH_HALF) : ph180_s;

  nmr_interval_counter #(.CNT_W(CNT_W)) u_interval (
    .clk      (PULSEPROG_CLK),
    .reset    (RESET),
    .load     (load_s),
    .load_val (load_val_s),
    .tc       (tc_s)
  );

  // Next-state, completion and echo-advance decode.
  always_comb begin
    next_state_s = state_r;
    done_s       = 1'b0;
    echo_inc_s   = 1'b0;
    if (ABORT) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (START) next_state_s = (t1p_s != '0) ? T1_P180 : P90;
          else       next_state_s = IDLE;
        end
        T1_P180: next_state_s = tc_s ? T1_DLY    : T1_P180;
        T1_DLY:  next_state_s = tc_s ? P90       : T1_DLY;
        P90:     next_state_s = tc_s ? DLY_NOACQ : P90;
        P180:    next_state_s = tc_s ? DLY_ACQ   : P180;
        DLY_NOACQ: begin
          if (!tc_s) begin
            next_state_s = DLY_NOACQ;
          end else if (echo_n_s == '0) begin
            next_state_s = IDLE;
            done_s       = 1'b1;
          end else begin
            next_state_s = P180;
          end
        end
        DLY_ACQ: begin
          if (!tc_s) begin
            next_state_s = DLY_ACQ;
          end else if (more_echo_s) begin
            next_state_s = P180;
            echo_inc_s   = 1'b1;
          end else begin
            next_state_s = IDLE;
            done_s       = 1'b1;
          end
        end
        default: next_state_s = IDLE;
      endcase
    end
    if (ABORT || start_s) next_echo_s = '0;
    else if (echo_inc_s)  next_echo_s = echo_cnt_r + ONE;
    else                  next_echo_s = echo_cnt_r;
  end

  // Interval length for the state being entered.
  always_comb begin
    load_val_s = '0;
    case (next_state_s)
      T1_P180:   load_val_s = t1p_s;
      T1_DLY:    load_val_s = t1d_s;
      P90:       load_val_s = p90_s;
      DLY_NOACQ: load_val_s = dna_s;
      P180:      load_val_s = p180_s;
      DLY_ACQ:   load_val_s = dacq_s;
      default:   load_val_s = '0;
    endcase
  end

  // Shadow configuration captured when a scan starts.
  always_ff @(posedge PULSEPROG_CLK) begin
    if (RESET) begin
      {t1p_r, t1d_r, p90_r, dna_r, p180_r, dacq_r, echo_n_r, samp_r, rxd_r} <= '0;
      {ph90_r, ph180_r, pc_r} <= '0;
    end else if (start_s) begin
      {t1p_r, t1d_r, p90_r, dna_r, p180_r} <= {T1_PULSE180, T1_DELAY, PULSE90, DELAY_NO_ACQ, PULSE180};
      {dacq_r, echo_n_r, samp_r, rxd_r}    <= {DELAY_WITH_ACQ, ECHO_PER_SCAN, SAMPLES_PER_ECHO, RX_DELAY};
      {ph90_r, ph180_r, pc_r}              <= {PH90, PH180, PHASE_CYCLE};
    end
  end

  // State and registered output decode of the state being entered.
  always_ff @(posedge PULSEPROG_CLK) begin
    if (RESET) begin
      state_r    <= IDLE;
      fsmstat_r  <= 1'b0;
      tx_gate_r  <= 1'b0;
      rf_phase_r <= '0;
      en_rx_r    <= 1'b0;
      acq_wnd_r  <= 1'b0;
      done_r     <= 1'b0;
      echo_cnt_r <= '0;
      pos_r      <= '0;
    end else begin
      state_r    <= next_state_s;
      fsmstat_r  <= (next_state_s != IDLE);
      tx_gate_r  <= (next_state_s == T1_P180) || (next_state_s == P90) || (next_state_s == P180);
      en_rx_r    <= (next_state_s == DLY_ACQ);
      acq_wnd_r  <= (next_state_s == DLY_ACQ) && win_s;
      done_r     <= done_s;
      echo_cnt_r <= next_echo_s;
      pos_r      <= (next_state_s == DLY_ACQ) ? next_pos_s : '0;
      if (ABORT)                                                  rf_phase_r <= '0;
      else if ((next_state_s == T1_P180) || (next_state_s == P90)) rf_phase_r <= ph90_s;
      else if (next_state_s == P180)                               rf_phase_r <= p180_ph_s;
      else                                                         rf_phase_r <= rf_phase_r;
    end
  end

  assign FSMSTAT  = fsmstat_r;
  assign TX_GATE  = tx_gate_r;
  assign RF_PHASE = rf_phase_r;
  assign EN_RX    = en_rx_r;
  assign TX_SD    = en_rx_r;
  assign ACQ_WND  = acq_wnd_r;
  assign ECHO_IDX = echo_cnt_r[ECHO_W-1:0];
  assign DONE     = done_r;

endmodule

// File: tb/tb_cpmg_seq_engine.sv
// Scoreboard bench for cpmg_seq_engine: a segment-level scan model fills a per-cycle expectation queue.
module tb_cpmg_seq_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RESET, START, ABORT, PHASE_CYCLE;
  logic [31:0] T1_PULSE180, T1_DELAY, PULSE90, DELAY_NO_ACQ, PULSE180, DELAY_WITH_ACQ;
  logic [31:0] ECHO_PER_SCAN, SAMPLES_PER_ECHO, RX_DELAY;
  logic [1:0]  PH90, PH180, RF_PHASE;
  logic        FSMSTAT, TX_GATE, EN_RX, TX_SD, ACQ_WND, DONE;
  logic [15:0] ECHO_IDX;

  cpmg_seq_engine dut (
    .PULSEPROG_CLK(clk), .RESET(RESET), .START(START), .ABORT(ABORT),
    .T1_PULSE180(T1_PULSE180), .T1_DELAY(T1_DELAY), .PULSE90(PULSE90),
    .DELAY_NO_ACQ(DELAY_NO_ACQ), .PULSE180(PULSE180), .DELAY_WITH_ACQ(DELAY_WITH_ACQ),
    .ECHO_PER_SCAN(ECHO_PER_SCAN), .SAMPLES_PER_ECHO(SAMPLES_PER_ECHO), .RX_DELAY(RX_DELAY),
    .PH90(PH90), .PH180(PH180), .PHASE_CYCLE(PHASE_CYCLE),
    .FSMSTAT(FSMSTAT), .TX_GATE(TX_GATE), .RF_PHASE(RF_PHASE), .EN_RX(EN_RX),
    .TX_SD(TX_SD), .ACQ_WND(ACQ_WND), .ECHO_IDX(ECHO_IDX), .DONE(DONE)
  );

  typedef struct {
    logic [31:0] t1p, t1d, p90, dna, p180, dacq, echo, samp, rxd;
    logic [1:0]  ph90, ph180;
    logic        pc;
  } cfg_t;

  typedef struct {
    int          cyc;
    logic        fsm, tx, en, acq, done;
    logic [1:0]  ph;
    logic [15:0] echo;
    logic        chk_echo;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [1:0] last_ph = 2'd0;
  bit         mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint len1(input logic [31:0] v);
    return (v == 32'd0) ? 64'd1 : longint'(v);
  endfunction

  task automatic apply(input cfg_t k);
    T1_PULSE180 = k.t1p; T1_DELAY = k.t1d; PULSE90 = k.p90; DELAY_NO_ACQ = k.dna;
    PULSE180 = k.p180; DELAY_WITH_ACQ = k.dacq; ECHO_PER_SCAN = k.echo;
    SAMPLES_PER_ECHO = k.samp; RX_DELAY = k.rxd; PH90 = k.ph90; PH180 = k.ph180;
    PHASE_CYCLE = k.pc;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t k;
    k.t1p   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 6)) : 32'd0;
    k.t1d   = 32'($urandom_range(0, 8));
    k.p90   = 32'($urandom_range(0, 6));
    k.dna   = 32'($urandom_range(0, 8));
    k.p180  = 32'($urandom_range(0, 6));
    k.dacq  = 32'($urandom_range(0, 16));
    k.echo  = 32'($urandom_range(0, 4));
    k.samp  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 8));
    k.rxd   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : 32'($urandom_range(0, 12));
    k.ph90  = 2'($urandom_range(0, 3));
    k.ph180 = 2'($urandom_range(0, 3));
    k.pc    = 1'($urandom_range(0, 1));
    return k;
  endfunction

  // One segment of n cycles; acquisition is high at in-segment positions [rx, rx+sm).
  task automatic emit(inout int c, input longint n, input logic tx, input logic [1:0] ph,
                      input logic en, input logic [15:0] echo, input longint rx, input longint sm);
    for (longint i = 0; i < n; i++) begin
      exp_t e;
      if (tx) last_ph = ph;
      e.cyc = c; e.fsm = 1'b1; e.tx = tx; e.en = en;
      e.acq = en && (i >= rx) && (i < rx + sm);
      e.done = 1'b0; e.ph = last_ph; e.echo = echo; e.chk_echo = 1'b1;
      q.push_back(e);
      c++;
    end
  endtask

  // Whole scan from its first busy cycle s; d returns the DONE cycle.
  task automatic gen_scan(input cfg_t k, input int s, output int d);
    int   c = s;
    exp_t e;
    if (k.t1p != 32'd0) begin
      emit(c, len1(k.t1p), 1'b1, k.ph90, 1'b0, 16'd0, 64'd0, 64'd0);
      emit(c, len1(k.t1d), 1'b0, k.ph90, 1'b0, 16'd0, 64'd0, 64'd0);
    end
    emit(c, len1(k.p90), 1'b1, k.ph90, 1'b0, 16'd0, 64'd0, 64'd0);
    emit(c, len1(k.dna), 1'b0, k.ph90, 1'b0, 16'd0, 64'd0, 64'd0);
    for (longint n = 0; n < longint'(k.echo); n++) begin
      int ph = (int'(k.ph180) + ((k.pc && (n % 2 == 1)) ? 2 : 0)) % 4;
      emit(c, len1(k.p180), 1'b1, 2'(ph), 1'b0, 16'(n), 64'd0, 64'd0);
      emit(c, len1(k.dacq), 1'b0, 2'(ph), 1'b1, 16'(n), longint'(k.rxd), longint'(k.samp));
    end
    e.cyc = c; e.fsm = 1'b0; e.tx = 1'b0; e.en = 1'b0; e.acq = 1'b0; e.done = 1'b1;
    e.ph = last_ph; e.echo = 16'd0; e.chk_echo = 1'b0;
    q.push_back(e);
    d = c;
  endtask

  // Start a scan; optionally scramble inputs and pulse START while busy.
  task automatic run_scan(input cfg_t k, input bit junk, input bit busy_start, output int s, output int d);
    apply(k);
    START = 1'b1;
    s = cyc + 1;
    gen_scan(k, s, d);
    tick();
    START = 1'b0;
    if (junk) apply(rand_cfg());
    if (busy_start) START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Abort or reset seen at the next edge: expect reset values there.
  task automatic kill(input bit use_reset, input bit with_start);
    exp_t e;
    int   a = cyc;
    if (use_reset) RESET = 1'b1; else ABORT = 1'b1;
    if (with_start) START = 1'b1;
    while (q.size() > 0 && q[$].cyc > a) void'(q.pop_back());
    e.cyc = a + 1; e.fsm = 1'b0; e.tx = 1'b0; e.en = 1'b0; e.acq = 1'b0; e.done = 1'b0;
    e.ph = 2'd0; e.echo = 16'd0; e.chk_echo = 1'b1;
    q.push_back(e);
    last_ph = 2'd0;
    tick();
    RESET = 1'b0; ABORT = 1'b0; START = 1'b0;
  endtask

  // Monitor: compare against the expectation for this cycle, or require quiet outputs.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [7:0] act, req;
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++; errors++;
        $display("FAIL missed_expectation cyc=%0d now=%0d", e.cyc, cyc);
      end
      act = {FSMSTAT, TX_GATE, EN_RX, TX_SD, ACQ_WND, DONE, RF_PHASE};
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        req = {e.fsm, e.tx, e.en, e.en, e.acq, e.done, e.ph};
        checks++;
        if (act !== req || (e.chk_echo && ECHO_IDX !== e.echo)) begin
          errors++;
          $display("FAIL cycle_outputs cyc=%0d fsm/tx/en/sd/acq/done/ph got %b echo=%0d want %b echo=%0d",
                   cyc, act, ECHO_IDX, req, e.echo);
        end
      end else begin
        checks++;
        if (act[7:2] !== 6'b0) begin
          errors++;
          $display("FAIL idle_outputs cyc=%0d fsm/tx/en/sd/acq/done got %b want 000000", cyc, act[7:2]);
        end
      end
    end
  end

  initial begin
    cfg_t k;
    int   s, d, d2;
    exp_t e;
    RESET = 1'b1; START = 1'b0; ABORT = 1'b0;
    k = '{default: '0};
    apply(k);
    tick(); tick();
    e.cyc = cyc; e.fsm = 1'b0; e.tx = 1'b0; e.en = 1'b0; e.acq = 1'b0; e.done = 1'b0;
    e.ph = 2'd0; e.echo = 16'd0; e.chk_echo = 1'b1;
    q.push_back(e);
    mon_en = 1'b1;
    RESET = 1'b0;

    // Long CPMG: 5 echoes, 30-sample windows 20 cycles into each delay, phase cycling 1,3,1,3,1.
    k = '{t1p: 32'd0, t1d: 32'd0, p90: 32'd64, dna: 32'd64, p180: 32'd128, dacq: 32'd512,
          echo: 32'd5, samp: 32'd30, rxd: 32'd20, ph90: 2'd0, ph180: 2'd1, pc: 1'b1};
    run_scan(k, 1'b1, 1'b1, s, d);
    while (cyc <= d) tick();
    tick();

    // T1 inversion section; window starting at 500 clipped to 12 cycles.
    k = '{t1p: 32'd100, t1d: 32'd200, p90: 32'd64, dna: 32'd64, p180: 32'd128, dacq: 32'd512,
          echo: 32'd2, samp: 32'd30, rxd: 32'd500, ph90: 2'd2, ph180: 2'd3, pc: 1'b0};
    run_scan(k, 1'b1, 1'b0, s, d);
    while (cyc <= d) tick();
    tick(); tick();

    // Abort mid-DLY_ACQ of echo 2, then a clean restart.
    k = '{t1p: 32'd0, t1d: 32'd0, p90: 32'd8, dna: 32'd8, p180: 32'd6, dacq: 32'd20,
          echo: 32'd5, samp: 32'd4, rxd: 32'd3, ph90: 2'd1, ph180: 2'd2, pc: 1'b1};
    run_scan(k, 1'b0, 1'b0, s, d);
    d2 = s + 8 + 8 + 2 * (6 + 20) + 6 + 10;
    while (cyc < d2) tick();
    kill(1'b0, 1'b1);
    tick(); tick();
    run_scan(k, 1'b0, 1'b0, s, d);
    while (cyc <= d) tick();
    tick();

    // ABORT together with START while idle: no scan may begin.
    kill(1'b0, 1'b1);
    tick(); tick();

    // ECHO_PER_SCAN=0 with START held: two back-to-back short scans.
    k = '{t1p: 32'd0, t1d: 32'd0, p90: 32'd5, dna: 32'd7, p180: 32'd4, dacq: 32'd9,
          echo: 32'd0, samp: 32'd3, rxd: 32'd1, ph90: 2'd3, ph180: 2'd0, pc: 1'b0};
    apply(k);
    START = 1'b1;
    s = cyc + 1;
    gen_scan(k, s, d);
    gen_scan(k, d + 1, d2);
    while (cyc < d + 1) tick();
    START = 1'b0;
    while (cyc <= d2) tick();
    tick();

    // Reset in the middle of the first 180 pulse.
    k.echo = 32'd3; k.p180 = 32'd10;
    run_scan(k, 1'b0, 1'b0, s, d);
    d2 = s + 5 + 7 + 5;
    while (cyc < d2) tick();
    kill(1'b1, 1'b0);
    tick();

    // Randomized scans, including zero-length intervals and extreme window settings.
    for (int n = 0; n < 40; n++) begin
      k = rand_cfg();
      run_scan(k, 1'b1, 1'($urandom_range(0, 1)), s, d);
      while (cyc <= d) tick();
      repeat ($urandom_range(0, 3)) tick();
    end

    for (int i = 0; i < 200 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      errors++; checks++;
      $display("FAIL queue_drain pending=%0d want 0", q.size());
    end
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
